dcache_miss_ctrl: RTL

Miss controller for the dual-issue data cache in the MEM stage. It takes the two per-lane miss requests (lane 1 older, lane 2 younger) and serialises them onto the single memory bus. For a read miss with a dirty victim, it writes the victim back first, then fills the line beat by beat into the cache arrays. Store misses are write-around: one sized bus write, no allocate. Each lane gets a one-cycle done pulse that releases its stall.

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/miss_req_arb.sv | 61 ++++++
 rtl/dcache_miss_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dcache_pkg
// Brief   : Shared types and helpers for the data-cache miss controller.
// Revision: 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int BEATS     = 8;
    localparam int BEAT_BITS = 3;
    localparam int OFF_BITS  = 3;
    localparam int LINE_BITS = BEAT_BITS + OFF_BITS;

    localparam logic [2:0] SIZE_D = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_WB       = 3'd2,
        S_FILL_REQ = 3'd3,
        S_FILL     = 3'd4,
        S_STORE    = 3'd5,
        S_DONE     = 3'd6
    } miss_state_t;

    typedef struct packed {
        logic [63:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [63:0] wdata;
    } miss_req_t;

    function automatic logic [63:0] line_addr(input logic [63:0] a);
        line_addr = {a[63:LINE_BITS], {LINE_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/miss_req_arb.sv
`default_nettype none
// ============================================================================
// Module  : miss_req_arb
// Brief   : Fixed-priority lane grant, request latch and same-line load merge.
// Revision: 1.0 - initial release
// ============================================================================
module miss_req_arb
    import dcache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_latch,
    input  logic        i_miss1,
    input  logic [63:0] i_addr1,
    input  logic        i_write1,
    input  logic [2:0]  i_size1,
    input  logic [63:0] i_wdata1,
    input  logic        i_miss2,
    input  logic [63:0] i_addr2,
    input  logic        i_write2,
    input  logic [2:0]  i_size2,
    input  logic [63:0] i_wdata2,
    output miss_req_t   o_req,
    output logic        o_lane2,
    output logic        o_merged,
    output logic        o_any
);

    miss_req_t r_req;
    logic      r_lane2;
    logic      r_merged;
    logic      w_merge;

    assign o_any   = i_miss1 | i_miss2;
    // Two loads to the same line are serviced by one fill; lane 1 owns the grant.
    assign w_merge = i_miss1 & i_miss2 & ~i_write1 & ~i_write2 &
                     (line_addr(i_addr1) == line_addr(i_addr2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req    <= '0;
            r_lane2  <= 1'b0;
            r_merged <= 1'b0;
        end else if (i_latch && o_any) begin
            if (i_miss1) begin
                r_req   <= '{addr: i_addr1, write: i_write1, size: i_size1, wdata: i_wdata1};
                r_lane2 <= 1'b0;
            end else begin
                r_req   <= '{addr: i_addr2, write: i_write2, size: i_size2, wdata: i_wdata2};
                r_lane2 <= 1'b1;
            end
            r_merged <= w_merge;
        end
    end

    assign o_req    = r_req;
    assign o_lane2  = r_lane2;
    assign o_merged = r_merged;

endmodule
`default_nettype wire

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dcache_miss_ctrl
// Brief   : Dual-lane data-cache miss controller: writeback, line fill, store.
// Revision: 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 miss1,
    input  logic [63:0]          addr1,
    input  logic                 write1,
    input  logic [2:0]           size1,
    input  logic [63:0]          wdata1,
    input  logic                 miss2,
    input  logic [63:0]          addr2,
    input  logic                 write2,
    input  logic [2:0]           size2,
    input  logic [63:0]          wdata2,
    output logic                 done1,
    output logic                 done2,
    output logic                 busy,
    input  logic                 victim_dirty,
    input  logic [63:0]          victim_addr,
    output logic [BEAT_BITS-1:0] victim_beat,
    input  logic [63:0]          victim_rdata,
    output logic                 bus_req,
    output logic                 bus_write,
    output logic [63:0]          bus_addr,
    output logic [2:0]           bus_size,
    output logic [63:0]          bus_wdata,
    input  logic                 bus_ready,
    input  logic                 bus_rvalid,
    input  logic [63:0]          bus_rdata,
    output logic                 fill_we,
    output logic [63:0]          fill_addr,
    output logic [BEAT_BITS-1:0] fill_beat,
    output logic [63:0]          fill_data
);

    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BEATS - 1);

    miss_state_t          r_state;
    logic [BEAT_BITS-1:0] r_cnt;
    logic [63:0]          r_victim;
    logic                 r_fill_we;
    logic [BEAT_BITS-1:0] r_fill_beat;
    logic [63:0]          r_fill_data;
    logic [63:0]          r_fill_addr;

    miss_req_t w_req;
    logic      w_lane2;
    logic      w_merged;
    logic      w_any;
    logic      w_idle;

    assign w_idle = (r_state == S_IDLE);

    miss_req_arb u_arb (
        .clk      (clk),
        .rst      (reset),
        .i_latch  (w_idle),
        .i_miss1  (miss1),
        .i_addr1  (addr1),
        .i_write1 (write1),
        .i_size1  (size1),
        .i_wdata1 (wdata1),
        .i_miss2  (miss2),
        .i_addr2  (addr2),
        .i_write2 (write2),
        .i_size2  (size2),
        .i_wdata2 (wdata2),
        .o_req    (w_req),
        .o_lane2  (w_lane2),
        .o_merged (w_merged),
        .o_any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_victim    <= '0;
            r_fill_we   <= 1'b0;
            r_fill_beat <= '0;
            r_fill_data <= '0;
            r_fill_addr <= '0;
        end else begin
            r_fill_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) r_state <= S_GRANT;
                end
                S_GRANT: begin
                    r_cnt <= '0;
                    if (w_req.write) begin
                        r_state <= S_STORE;
                    end else if (victim_dirty) begin
                        r_victim <= victim_addr;
                        r_state  <= S_WB;
                    end else begin
                        r_state <= S_FILL_REQ;
                    end
                end
                S_WB: begin
                    if (bus_ready) begin
                        r_cnt <= r_cnt + BEAT_BITS'(1);
                        if (r_cnt == BEAT_LAST) r_state <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    if (bus_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus_rvalid) begin
                        r_fill_we   <= 1'b1;
                        r_fill_beat <= r_cnt;
                        r_fill_data <= bus_rdata;
                        r_fill_addr <= line_addr(w_req.addr);
                        r_cnt       <= r_cnt + BEAT_BITS'(1);
                    end
                    // Leave only once the final beat has actually been written.
                    if (r_fill_we && (r_fill_beat == BEAT_LAST)) r_state <= S_DONE;
                end
                S_STORE: begin
                    if (bus_ready) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus_req     = 1'b0;
        bus_write   = 1'b0;
        bus_addr    = '0;
        bus_size    = '0;
        bus_wdata   = '0;
        victim_beat = '0;
        case (r_state)
            S_WB: begin
                bus_req     = 1'b1;
                bus_write   = 1'b1;
                bus_addr    = r_victim + {{(64-LINE_BITS){1'b0}}, r_cnt, {OFF_BITS{1'b0}}};
                bus_size    = SIZE_D;
                bus_wdata   = victim_rdata;
                victim_beat = r_cnt;
            end
            S_FILL_REQ: begin
                bus_req  = 1'b1;
                bus_addr = line_addr(w_req.addr);
                bus_size = SIZE_D;
            end
            S_STORE: begin
                bus_req   = 1'b1;
                bus_write = 1'b1;
                bus_addr  = w_req.addr;
                bus_size  = w_req.size;
                bus_wdata = w_req.wdata;
            end
            default: ;
        endcase
    end

    assign done1     = (r_state == S_DONE) & (~w_lane2 | w_merged);
    assign done2     = (r_state == S_DONE) & (w_lane2 | w_merged);
    assign busy      = ~w_idle;
    assign fill_we   = r_fill_we;
    assign fill_beat = r_fill_beat;
    assign fill_data = r_fill_data;
    assign fill_addr = r_fill_addr;

endmodule
`default_nettype wire
